// File: rtl/mc_pkg.sv
// Instruction encodings, decoded instruction kinds and FSM state type for the multicycle datapath.
package mc_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_DWORD  = 3'b011;
   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_BEQ    = 3'b000;

   localparam logic [6:0] F7_ADD    = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0100000;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      K_ILL, K_LD, K_SD, K_ADD, K_SUB, K_ADDI, K_BEQ
   } kind_t;

   function automatic kind_t decode_kind(input logic [31:0] ri);
      kind_t k;
      k = K_ILL;
      case (ri[6:0])
         OP_LOAD:   if (ri[14:12] == F3_DWORD) k = K_LD;
         OP_STORE:  if (ri[14:12] == F3_DWORD) k = K_SD;
         OP_IMM:    if (ri[14:12] == F3_ADD)   k = K_ADDI;
         OP_BRANCH: if (ri[14:12] == F3_BEQ)   k = K_BEQ;
         OP_REG: begin
            if (ri[14:12] == F3_ADD && ri[31:25] == F7_ADD) k = K_ADD;
            if (ri[14:12] == F3_ADD && ri[31:25] == F7_SUB) k = K_SUB;
         end
         default:   k = K_ILL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory request/ready buses of the multicycle datapath.
interface multicycle_datapath_if #(
   parameter int XLEN = 64
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ready;

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ready;

   modport master (
      output imem_req, imem_addr, input imem_rdata, imem_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ready
   );

   modport slave (
      input imem_req, imem_addr, output imem_rdata, imem_ready,
      input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/banco_reg_param.sv
// Register file: two async read ports, one sync write port, x0 hardwired to zero, async clear.
module banco_reg_param #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   localparam int IW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_i,
   input  logic [IW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [IW-1:0]   raddr1_i,
   input  logic [IW-1:0]   raddr2_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o
);
   logic [XLEN-1:0] regs_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != '0) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB core; 3-5 cycles per instruction plus one per memory wait cycle,
// requests held until ready, enable=0 freezes everything. beq only with MC_DATAPATH_BRANCH_EN, else it traps.
module multicycle_datapath
   import mc_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   multicycle_datapath_if.master bus,
   output logic                  halted,
   output logic [XLEN-1:0]       pc_out
);
   localparam int IW = $clog2(NREGS);

   state_t          state_q, state_d;
   logic            run_q;
   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic [31:0]     ri_q;
   logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
   logic [XLEN-1:0] imm, alu_res, rs1_val, rs2_val;
   kind_t           kind_raw, kind;
   logic            imem_hs;

   assign kind_raw = decode_kind(ri_q);
`ifdef MC_DATAPATH_BRANCH_EN
   assign kind = kind_raw;
`else
   assign kind = (kind_raw == K_BEQ) ? K_ILL : kind_raw;
`endif

   always_comb begin
      imm = {{(XLEN-12){ri_q[31]}}, ri_q[31:20]};
      if (kind == K_SD) imm = {{(XLEN-12){ri_q[31]}}, ri_q[31:25], ri_q[11:7]};
`ifdef MC_DATAPATH_BRANCH_EN
      if (kind == K_BEQ) imm = {{(XLEN-12){ri_q[31]}}, ri_q[7], ri_q[30:25], ri_q[11:8], 1'b0};
`endif
   end

   always_comb begin
      case (kind)
         K_ADD:   alu_res = a_q + b_q;
         K_SUB:   alu_res = a_q - b_q;
         default: alu_res = a_q + imm_q;
      endcase
   end

   assign pc_plus4 = pc_q + XLEN'(4);
   assign imem_hs  = bus.imem_req && bus.imem_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_FETCH:  if (imem_hs) state_d = ST_DECODE;
         ST_DECODE: state_d = (kind == K_ILL) ? ST_HALT : ST_EXEC;
         ST_EXEC: begin
            case (kind)
               K_LD, K_SD: state_d = ST_MEM;
`ifdef MC_DATAPATH_BRANCH_EN
               K_BEQ: begin
                  state_d = ST_FETCH;
                  pc_d    = (a_q == b_q) ? pc_q + imm_q : pc_plus4;
               end
`endif
               default:    state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (bus.dmem_ready) begin
               state_d = (kind == K_SD) ? ST_FETCH : ST_WB;
               if (kind == K_SD) pc_d = pc_plus4;
            end
         end
         ST_WB: begin
            state_d = ST_FETCH;
            pc_d    = pc_plus4;
         end
         default: ;
      endcase
   end

   // run_q keeps imem_req low until the first enabled edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         run_q   <= 1'b0;
         pc_q    <= PC_RESET;
         ri_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
      end else if (enable) begin
         state_q <= state_d;
         run_q   <= 1'b1;
         pc_q    <= pc_d;
         case (state_q)
            ST_FETCH:  if (imem_hs) ri_q <= bus.imem_rdata;
            ST_DECODE: begin
               a_q   <= rs1_val;
               b_q   <= rs2_val;
               imm_q <= imm;
            end
            ST_EXEC:   alu_q <= alu_res;
            ST_MEM:    if (bus.dmem_ready) mdr_q <= bus.dmem_rdata;
            default: ;
         endcase
      end
   end

   banco_reg_param #(.XLEN(XLEN), .NREGS(NREGS)) u_regs (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (enable && state_q == ST_WB),
      .waddr_i  (ri_q[7 +: IW]),
      .wdata_i  ((kind == K_LD) ? mdr_q : alu_q),
      .raddr1_i (ri_q[15 +: IW]),
      .raddr2_i (ri_q[20 +: IW]),
      .rdata1_o (rs1_val),
      .rdata2_o (rs2_val)
   );

   assign bus.imem_req   = (state_q == ST_FETCH) && run_q;
   assign bus.imem_addr  = pc_q;
   assign bus.dmem_req   = (state_q == ST_MEM);
   assign bus.dmem_we    = (state_q == ST_MEM) && (kind == K_SD);
   assign bus.dmem_addr  = alu_q;
   assign bus.dmem_wdata = b_q;
   assign halted         = (state_q == ST_HALT);
   assign pc_out         = pc_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: hand-assembled programs run against zero-wait imem and a dmem with programmable wait states.
module tb_multicycle_datapath;
   localparam int          XLEN = 64;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ILL  = 32'h0000_007F;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic            enable   = 1'b0;
   logic            clr_dmem = 1'b1;
   logic            halted;
   logic [XLEN-1:0] pc_out;

   int checks     = 0;
   int failures   = 0;
   int dmem_delay = 0;
   int dwait      = 0;
   int cyc        = 0;

   logic [31:0] imem [64];
   logic [63:0] dmem [16];

   logic [63:0] fetch_addr_q [$];
   int          fetch_cyc_q  [$];
   logic [63:0] d_addr_q [$];
   logic [63:0] d_data_q [$];
   logic        d_we_q   [$];
   int          d_len_q  [$];
   int          ireq_cnt    = 0;
   int          overlap_cnt = 0;
   int          dlen        = 0;

   multicycle_datapath_if #(.XLEN(XLEN)) bus ();

   multicycle_datapath #(.XLEN(XLEN), .NREGS(32), .PC_RESET(64'h0)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .bus    (bus),
      .halted (halted),
      .pc_out (pc_out)
   );

   always #5 clk = ~clk;

   assign bus.imem_rdata = imem[bus.imem_addr[7:2]];
   assign bus.imem_ready = bus.imem_req;
   assign bus.dmem_rdata = dmem[bus.dmem_addr[6:3]];
   assign bus.dmem_ready = bus.dmem_req && (dwait >= dmem_delay);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.dmem_req && !bus.dmem_ready) dwait <= dwait + 1;
      else                                 dwait <= 0;
      if (clr_dmem) begin
         for (int i = 0; i < 16; i++) dmem[i] <= 64'hDEAD_0000_0000_0000 | 64'(i);
      end else if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
         dmem[bus.dmem_addr[6:3]] <= bus.dmem_wdata;
      end
   end

   always @(negedge clk) begin
      if (bus.imem_req) ireq_cnt++;
      if (bus.imem_req && bus.dmem_req) overlap_cnt++;
      if (bus.imem_req && bus.imem_ready) begin
         fetch_addr_q.push_back(bus.imem_addr);
         fetch_cyc_q.push_back(cyc);
      end
      if (!rst_n) dlen = 0;
      else if (bus.dmem_req) dlen++;
      if (bus.dmem_req && bus.dmem_ready) begin
         d_addr_q.push_back(bus.dmem_addr);
         d_data_q.push_back(bus.dmem_we ? bus.dmem_wdata : bus.dmem_rdata);
         d_we_q.push_back(bus.dmem_we);
         d_len_q.push_back(dlen);
         dlen = 0;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%h expected=0x%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_halt(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = halted;
      end
   endtask

   task automatic wait_fetches(input int n, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = (fetch_addr_q.size() >= n);
      end
   endtask

   task automatic assert_reset();
      @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_branch(input logic [31:0] br);
      for (int i = 0; i < 64; i++) imem[i] = NOP;
      imem[0] = 32'h0050_0093;  // addi x1,x0,5
      imem[1] = 32'h0030_0113;  // addi x2,x0,3
      imem[8] = br;             // at 0x20
      imem[9] = ILL;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   b;
      int   db;
      int   n0;
      logic ok;

      for (int i = 0; i < 64; i++) imem[i] = ILL;
      imem[0]  = 32'h0050_0093;  // addi x1,x0,5
      imem[1]  = 32'h0030_0113;  // addi x2,x0,3
      imem[2]  = 32'h0020_81B3;  // add  x3,x1,x2
      imem[3]  = 32'h4011_0233;  // sub  x4,x2,x1
      imem[4]  = 32'h0030_3823;  // sd   x3,16(x0)
      imem[5]  = 32'h0100_3283;  // ld   x5,16(x0)
      imem[6]  = 32'h0070_0013;  // addi x0,x0,7
      imem[7]  = 32'h0250_3023;  // sd   x5,32(x0)
      imem[8]  = 32'h0040_3C23;  // sd   x4,24(x0)
      imem[9]  = 32'h0200_3423;  // sd   x0,40(x0)
      imem[10] = ILL;

      enable = 1'b1;
      repeat (3) tick();
      check_eq("rst_imem_req", bus.imem_req, 0);
      check_eq("rst_dmem_req", bus.dmem_req, 0);
      check_eq("rst_dmem_we", bus.dmem_we, 0);
      check_eq("rst_halted", halted, 0);
      check_eq("rst_pc", pc_out, 0);

      clr_dmem   = 1'b0;
      dmem_delay = 3;
      b  = fetch_addr_q.size();
      db = d_addr_q.size();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("req_before_first_edge", bus.imem_req, 0);

      wait_halt(600, ok);
      check_eq("prog_a_halts", ok, 1);
      check_eq("first_fetch_addr", fetch_addr_q[b], 0);
      check_eq("lat_addi", fetch_cyc_q[b+1] - fetch_cyc_q[b], 4);
      check_eq("lat_add", fetch_cyc_q[b+3] - fetch_cyc_q[b+2], 4);
      check_eq("lat_sd_wait3", fetch_cyc_q[b+5] - fetch_cyc_q[b+4], 7);
      check_eq("lat_ld_wait3", fetch_cyc_q[b+6] - fetch_cyc_q[b+5], 8);

      check_eq("sd_addr", d_addr_q[db], 16);
      check_eq("sd_wdata", d_data_q[db], 8);
      check_eq("sd_we", d_we_q[db], 1);
      check_eq("sd_req_cycles", d_len_q[db], 4);
      check_eq("ld_addr", d_addr_q[db+1], 16);
      check_eq("ld_we", d_we_q[db+1], 0);
      check_eq("ld_req_cycles", d_len_q[db+1], 4);
      check_eq("mem_x3_add", dmem[2], 64'd8);
      check_eq("mem_x4_sub", dmem[3], 64'hFFFF_FFFF_FFFF_FFFE);
      check_eq("mem_x5_load", dmem[4], 64'd8);
      check_eq("mem_x0_zero", dmem[5], 64'd0);
      check_eq("dmem_txn_count", d_addr_q.size() - db, 5);

      check_eq("ill_halted", halted, 1);
      check_eq("ill_pc", pc_out, 64'h28);
      n0 = ireq_cnt;
      repeat (10) tick();
      check_eq("no_fetch_after_halt", ireq_cnt - n0, 0);
      check_eq("halt_sticky", halted, 1);

      // Hold in reset release with enable low, then run and yank reset mid-MEM.
      assert_reset();
      enable = 1'b0;
      release_reset();
      repeat (5) tick();
      check_eq("en0_no_req", bus.imem_req, 0);
      check_eq("en0_halted_clear", halted, 0);
      check_eq("en0_pc", pc_out, 0);
      @(negedge clk);
      enable = 1'b1;
      tick();
      check_eq("en1_req", bus.imem_req, 1);
      check_eq("en1_addr", bus.imem_addr, 0);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         ok = bus.dmem_req;
      end
      check_eq("reach_mem", ok, 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_mem_dreq", bus.dmem_req, 0);
      check_eq("rst_mid_mem_ireq", bus.imem_req, 0);
      check_eq("rst_mid_mem_pc", pc_out, 0);
      b = fetch_addr_q.size();
      @(negedge clk);
      rst_n = 1'b1;
      wait_fetches(b + 1, 20, ok);
      check_eq("resume_seen", ok, 1);
      check_eq("resume_addr", fetch_addr_q[b], 0);

`ifdef MC_DATAPATH_BRANCH_EN
      assert_reset();
      load_branch(32'hFE10_8CE3);  // beq x1,x1,-8
      b = fetch_addr_q.size();
      release_reset();
      wait_fetches(b + 10, 300, ok);
      check_eq("beq_taken_seen", ok, 1);
      check_eq("beq_taken_at", fetch_addr_q[b+8], 64'h20);
      check_eq("beq_taken_target", fetch_addr_q[b+9], 64'h18);
      check_eq("beq_latency", fetch_cyc_q[b+9] - fetch_cyc_q[b+8], 3);

      assert_reset();
      load_branch(32'hFE20_8CE3);  // beq x1,x2,-8
      b = fetch_addr_q.size();
      release_reset();
      wait_halt(300, ok);
      check_eq("beq_nt_halts", ok, 1);
      check_eq("beq_nt_next", fetch_addr_q[b+9], 64'h24);
      check_eq("beq_nt_pc", pc_out, 64'h24);
`else
      assert_reset();
      load_branch(32'hFE10_8CE3);  // beq x1,x1,-8
      b = fetch_addr_q.size();
      release_reset();
      wait_halt(300, ok);
      check_eq("beq_off_halts", ok, 1);
      check_eq("beq_off_halted", halted, 1);
      check_eq("beq_off_pc", pc_out, 64'h20);
      check_eq("beq_off_fetches", fetch_addr_q.size() - b, 9);
`endif

      check_eq("no_req_overlap", overlap_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameters SHALL be: XLEN, default 64, data/address width; NREGS, default 32, register count (power of 2, 2..32); PC_RESET, default 0, PC value after reset.
REQ-002 Ports SHALL be: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-003 enable in 1: when 0, FSM, PC, RI and register file hold; outputs keep their values.
REQ-004 imem_req out 1 fetch request; imem_addr out XLEN byte address (PC); imem_rdata in 32 instruction; imem_ready in 1 instruction valid.
REQ-005 dmem_req out 1; dmem_we out 1 (1 = store); dmem_addr out XLEN; dmem_wdata out XLEN; dmem_rdata in XLEN; dmem_ready in 1 access complete.
REQ-006 halted out 1 illegal instruction trap; pc_out out XLEN current PC (debug).

Function
REQ-007 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-008 FETCH: imem_req=1, imem_addr=PC; req held until imem_ready=1 is sampled; then RI<=imem_rdata, next DECODE.
REQ-009 DECODE: read rs1=RI[19:15], rs2=RI[24:20] into A/B registers; build immediate; next EXEC, or HALT if illegal.
REQ-010 Supported: ld (opcode 0000011, f3 011), sd (0100011, f3 011), add/sub (0110011, f3 000, f7 0000000/0100000), addi (0010011, f3 000), beq (1100011, f3 000); any other encoding is illegal.
REQ-011 Immediates SHALL be sign-extended to XLEN: I-type RI[31:20]; S-type {RI[31:25],RI[11:7]}; B-type {RI[31],RI[7],RI[30:25],RI[11:8],0}.
REQ-012 EXEC: ALU computes A+imm (ld/sd/addi), A+B or A-B (add/sub), A-B zero test (beq); arithmetic modulo 2^XLEN, overflow ignored.
REQ-013 After EXEC: ld/sd -> MEM; add/sub/addi -> WB; beq -> FETCH with PC<=PC+imm if A==B else PC+4.
REQ-014 MEM: dmem_req=1, dmem_addr=ALU result, dmem_we=1 and dmem_wdata=B for sd; held until dmem_ready=1; sd then PC<=PC+4, next FETCH; ld latches dmem_rdata, next WB.
REQ-015 WB: rd=RI[11:7] written with ALU result or load data; PC<=PC+4; next FETCH.
REQ-016 Writes to register 0 SHALL be discarded; reads of register 0 return 0.
REQ-017 Register indices SHALL use the low log2(NREGS) bits; with NREGS<32 upper index bits are ignored.
REQ-018 Latency with zero-wait memories: add/sub/addi 4 cycles, beq 3, sd 4, ld 5; each wait cycle adds one.
REQ-019 HALT: halted=1, no requests, PC frozen at the faulting instruction; exit only via reset.
REQ-020 PC increments wrap modulo 2^XLEN.
REQ-021 imem_req and dmem_req SHALL never be asserted in the same cycle.

Reset
REQ-022 rst_n=0 SHALL immediately force: state FETCH, PC=PC_RESET, RI=0, all registers 0, imem_req=0, dmem_req=0, dmem_we=0, halted=0.
REQ-023 Reset asserted during a pending handshake SHALL abandon it; first request after release is a fetch from PC_RESET.
REQ-024 imem_req SHALL first assert the first clk edge after rst_n deasserts with enable=1.

Configuration
REQ-025 Macro MC_DATAPATH_BRANCH_EN: defined -> beq executes per REQ-013; undefined -> beq is illegal (HALT) and no B-type immediate or comparator logic is built.

Structure
REQ-026 Package mc_pkg SHALL hold opcode/funct3/funct7 constants and the FSM state enum.
REQ-027 Register file SHALL be sub-module banco_reg_param (parameters XLEN, NREGS; 2 async read ports, 1 sync write port, async active-low clear).

Verification
REQ-028 x1=5, x2=3 (addi from x0), then add x3,x1,x2 -> x3=8; sub x4,x2,x1 -> x4=0xFFFF_FFFF_FFFF_FFFE.
REQ-029 sd x3,16(x0) then ld x5,16(x0), dmem_ready delayed 3 cycles -> dmem_addr=16, dmem_wdata=8, x5=8, req held until ready.
REQ-030 addi x0,x0,7 -> x0 reads 0.
REQ-031 beq x1,x1,-8 at PC=0x20 -> next fetch 0x18; beq x1,x2 -> 0x24; without macro -> halted=1, pc_out=0x20.
REQ-032 Opcode 0x7F -> halted=1, no further imem_req; rst_n pulse mid-MEM -> dmem_req drops at once, fetch resumes at PC_RESET.
